// File: rtl/pool_stream_if.sv
// Streaming handshake bundle for pool_stream_engine.
//   mode        : 0 = max pooling, 1 = average pooling (latched per frame by the engine)
//   in_valid    : ifm carries a pixel
//   in_ready    : engine can take the pixel this cycle
//   ifm         : signed input pixel
//   out_valid   : data_output carries a pooled value
//   out_ready   : downstream takes data_output this cycle
//   data_output : signed pooled value
//   end_pool    : marks the final output beat of a frame
// master drives the input side and consumes the output side; slave is the engine.
interface pool_stream_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    logic                  mode;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] ifm;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] data_output;
    logic                  end_pool;

    modport master (
        output mode, in_valid, ifm, out_ready,
        input  in_ready, out_valid, data_output, end_pool
    );

    modport slave (
        input  mode, in_valid, ifm, out_ready,
        output in_ready, out_valid, data_output, end_pool
    );
endinterface

// File: rtl/pool_stream_engine.sv
// Single-clock streaming pooling engine with a K-row line buffer.
// Pixels arrive column fastest, then row, then channel; one pooled value leaves per complete
// KxK window in raster order, selectable max or floor-average, with a one-entry output register.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : pool_stream_if slave (mode, in_valid/in_ready/ifm, out_valid/out_ready/data_output,
//         end_pool)
module pool_stream_engine #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned IFM_SIZE    = 8,
    parameter int unsigned KERNEL_POOL = 2,
    parameter int unsigned STRIDE_POOL = 2,
    parameter int unsigned CI          = 3
) (
    input logic         clk,
    input logic         rst,
    pool_stream_if.slave bus
);
    localparam int unsigned OFM_SIZE = (IFM_SIZE - KERNEL_POOL) / STRIDE_POOL + 1;
    localparam int unsigned LOG2K    = $clog2(KERNEL_POOL);
    localparam int unsigned CW       = (IFM_SIZE > 1) ? $clog2(IFM_SIZE) : 1;
    localparam int unsigned CHW      = (CI > 1) ? $clog2(CI) : 1;
    localparam int unsigned SW       = DATA_WIDTH + 2 * LOG2K;
    // Row/column of the pixel that completes the last window of a channel.
    localparam int unsigned LAST     = (OFM_SIZE - 1) * STRIDE_POOL + KERNEL_POOL - 1;

    logic [CW-1:0]  col_q, col_d;
    logic [CW-1:0]  row_q, row_d;
    logic [CHW-1:0] ch_q, ch_d;
    logic           mode_q, mode_d;
    logic           out_valid_q, out_valid_d;
    logic           end_q, end_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    logic [DATA_WIDTH-1:0] lb_q [KERNEL_POOL][IFM_SIZE];

    logic in_ready_w;
    logic accept;
    logic col_last, row_last, ch_last;
    logic first_px;
    logic win_done;
    logic is_last;

    logic signed [DATA_WIDTH-1:0] win [KERNEL_POOL][KERNEL_POOL];
    logic signed [DATA_WIDTH-1:0] pool_max;
    logic signed [SW-1:0]         pool_sum;
    logic signed [DATA_WIDTH-1:0] pool_avg;
    logic signed [DATA_WIDTH-1:0] result;

    // One-entry output register: accept input whenever the slot is free or draining.
    assign in_ready_w = !out_valid_q || bus.out_ready;
    assign accept     = bus.in_valid && in_ready_w;

    assign col_last = (32'(col_q) == IFM_SIZE - 1);
    assign row_last = (32'(row_q) == IFM_SIZE - 1);
    assign ch_last  = (32'(ch_q) == CI - 1);
    assign first_px = (col_q == '0) && (row_q == '0) && (ch_q == '0);

    // Window ends here when both coordinates sit on a stride point of a full window.
    assign win_done = (32'(row_q) >= KERNEL_POOL - 1) && (32'(col_q) >= KERNEL_POOL - 1) &&
                      ((32'(row_q) - (KERNEL_POOL - 1)) % STRIDE_POOL == 0) &&
                      ((32'(col_q) - (KERNEL_POOL - 1)) % STRIDE_POOL == 0);
    assign is_last  = ch_last && (32'(row_q) == LAST) && (32'(col_q) == LAST);

    // Raster counters advance on acceptance only.
    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        ch_d   = ch_q;
        mode_d = mode_q;
        if (accept) begin
            if (first_px) begin
                mode_d = bus.mode;
            end
            if (col_last) begin
                col_d = '0;
                if (row_last) begin
                    row_d = '0;
                    ch_d  = ch_last ? '0 : ch_q + CHW'(1);
                end else begin
                    row_d = row_q + CW'(1);
                end
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    // Gather the KxK window; the bottom-right sample is the live pixel, the rest come from
    // the line buffer (row index is row mod K since K is a power of two).
    always_comb begin
        for (int i = 0; i < KERNEL_POOL; i++) begin
            for (int j = 0; j < KERNEL_POOL; j++) begin
                if (i == KERNEL_POOL - 1 && j == KERNEL_POOL - 1) begin
                    win[i][j] = bus.ifm;
                end else begin
                    win[i][j] = lb_q[LOG2K'(row_q - CW'(KERNEL_POOL - 1 - i))]
                                    [col_q - CW'(KERNEL_POOL - 1 - j)];
                end
            end
        end
    end

    always_comb begin
        pool_max = win[0][0];
        pool_sum = '0;
        for (int i = 0; i < KERNEL_POOL; i++) begin
            for (int j = 0; j < KERNEL_POOL; j++) begin
                if (win[i][j] > pool_max) begin
                    pool_max = win[i][j];
                end
                pool_sum = pool_sum + SW'(win[i][j]);
            end
        end
        // Arithmetic shift floors toward -inf; the mean always fits DATA_WIDTH.
        pool_avg = DATA_WIDTH'(pool_sum >>> (2 * LOG2K));
        result   = mode_q ? pool_avg : pool_max;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        data_d      = data_q;
        end_d       = end_q;
        if (accept && win_done) begin
            out_valid_d = 1'b1;
            data_d      = result;
            end_d       = is_last;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
            end_d       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q       <= '0;
            row_q       <= '0;
            ch_q        <= '0;
            mode_q      <= 1'b0;
            out_valid_q <= 1'b0;
            end_q       <= 1'b0;
            data_q      <= '0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            ch_q        <= ch_d;
            mode_q      <= mode_d;
            out_valid_q <= out_valid_d;
            end_q       <= end_d;
            data_q      <= data_d;
        end
    end

    // Line-buffer contents need no reset; stale rows are always overwritten before use.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb_q[row_q[LOG2K-1:0]][col_q] <= bus.ifm;
        end
    end

    assign bus.in_ready    = in_ready_w;
    assign bus.out_valid   = out_valid_q;
    assign bus.data_output = data_q;
    assign bus.end_pool    = end_q;
endmodule

// File: tb/tb_pool_stream_engine.sv
module tb_pool_stream_engine;
    localparam int unsigned DW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          mode_r;
    logic          in_valid_r;
    logic          out_ready_r;
    logic [DW-1:0] ifm_r;
    int            sel;

    // DUT A: IFM 4, K2, S2, CI3.  DUT B: IFM 3, K2, S1, CI1.
    pool_stream_if #(.DATA_WIDTH(DW)) ifa ();
    pool_stream_if #(.DATA_WIDTH(DW)) ifb ();

    pool_stream_engine #(
        .DATA_WIDTH(DW), .IFM_SIZE(4), .KERNEL_POOL(2), .STRIDE_POOL(2), .CI(3)
    ) dut_a (
        .clk(clk),
        .rst(rst),
        .bus(ifa)
    );

    pool_stream_engine #(
        .DATA_WIDTH(DW), .IFM_SIZE(3), .KERNEL_POOL(2), .STRIDE_POOL(1), .CI(1)
    ) dut_b (
        .clk(clk),
        .rst(rst),
        .bus(ifb)
    );

    assign ifa.mode      = mode_r;
    assign ifa.ifm       = ifm_r;
    assign ifa.in_valid  = in_valid_r && (sel == 0);
    assign ifa.out_ready = out_ready_r;
    assign ifb.mode      = mode_r;
    assign ifb.ifm       = ifm_r;
    assign ifb.in_valid  = in_valid_r && (sel == 1);
    assign ifb.out_ready = out_ready_r;

    logic          o_valid, o_end, i_ready;
    logic [DW-1:0] o_data;
    assign o_valid = (sel == 1) ? ifb.out_valid : ifa.out_valid;
    assign o_end   = (sel == 1) ? ifb.end_pool : ifa.end_pool;
    assign i_ready = (sel == 1) ? ifb.in_ready : ifa.in_ready;
    assign o_data  = (sel == 1) ? ifb.data_output : ifa.data_output;

    int            errors = 0;
    int            checks = 0;
    int            px_q[$];
    logic [DW-1:0] exp_d[$];
    logic          exp_e[$];
    logic [DW-1:0] got_d[$];
    logic          got_e[$];
    int            accept_cyc;

    typedef struct packed {
        logic               which;
        logic               m;
        logic [1:0]         kind;
        logic [3:0][DW-1:0] v;
    } vec_t;
    vec_t tbl [6];

    function automatic vec_t mk(logic w, logic m, logic [1:0] k, int a, int b, int c, int d);
        vec_t t;
        t.which = w;
        t.m     = m;
        t.kind  = k;
        t.v[0]  = 16'(a);
        t.v[1]  = 16'(b);
        t.v[2]  = 16'(c);
        t.v[3]  = 16'(d);
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // kind 0: ramp r*n+c; kind 1: 2x2 blocks of -(1..4)-4*block; kind 2: random signed.
    task automatic make_frame(input int kind, input int which);
        int n  = (which == 1) ? 3 : 4;
        int ci = (which == 1) ? 1 : 3;
        px_q.delete();
        for (int c = 0; c < ci; c++) begin
            for (int r = 0; r < n; r++) begin
                for (int col = 0; col < n; col++) begin
                    if (kind == 0) begin
                        px_q.push_back(r * n + col);
                    end else if (kind == 1) begin
                        px_q.push_back(-(1 + 2 * (r % 2) + (col % 2) + 4 * (2 * (r / 2) + col / 2)));
                    end else begin
                        px_q.push_back(int'($urandom_range(0, 65535)) - 32768);
                    end
                end
            end
        end
    endtask

    // Reference: enumerate output windows directly from the frame array.
    task automatic model(input int which, input logic m);
        int n   = (which == 1) ? 3 : 4;
        int s   = (which == 1) ? 1 : 2;
        int ci  = (which == 1) ? 1 : 3;
        int k   = 2;
        int ofm = (n - k) / s + 1;
        exp_d.delete();
        exp_e.delete();
        for (int c = 0; c < ci; c++) begin
            for (int oy = 0; oy < ofm; oy++) begin
                for (int ox = 0; ox < ofm; ox++) begin
                    int best;
                    int sum;
                    int q;
                    best = px_q[c * n * n + oy * s * n + ox * s];
                    sum  = 0;
                    for (int i = 0; i < k; i++) begin
                        for (int j = 0; j < k; j++) begin
                            int v;
                            v = px_q[c * n * n + (oy * s + i) * n + ox * s + j];
                            if (v > best) best = v;
                            sum += v;
                        end
                    end
                    q = sum / (k * k);
                    if (q * (k * k) > sum) q--;
                    exp_d.push_back(16'(m ? q : best));
                    exp_e.push_back(c == ci - 1 && oy == ofm - 1 && ox == ofm - 1);
                end
            end
        end
    endtask

    task automatic run_frame(input int which, input logic m, input logic rnd,
                             input int stall_at, input int stall_len, input logic toggle);
        int            total = px_q.size();
        int            sent  = 0;
        int            cyc   = 0;
        logic          prev_stall = 1'b0;
        logic [DW-1:0] prev_d = '0;
        logic          prev_e = 1'b0;
        got_d.delete();
        got_e.delete();
        sel        = which;
        accept_cyc = -1;
        while (!(sent == total && got_d.size() >= exp_d.size())) begin
            @(negedge clk);
            if (cyc >= 3000) begin
                checks++;
                errors++;
                $display("FAIL timeout: sent %0d of %0d, beats %0d of %0d",
                         sent, total, got_d.size(), exp_d.size());
                break;
            end
            in_valid_r = (sent < total) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
            if (sent < total) ifm_r = 16'(px_q[sent]);
            mode_r      = (sent != 0 && toggle) ? ~m : m;
            out_ready_r = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (cyc >= stall_at && cyc < stall_at + stall_len) out_ready_r = 1'b0;
            #1;
            if (prev_stall) begin
                check("hold_valid", o_valid, 1);
                check("hold_data", o_data, prev_d);
                check("hold_end", o_end, prev_e);
            end
            check("in_ready", i_ready, !o_valid || out_ready_r);
            prev_stall = o_valid && !out_ready_r;
            prev_d     = o_data;
            prev_e     = o_end;
            if (o_valid && out_ready_r) begin
                got_d.push_back(o_data);
                got_e.push_back(o_end);
            end
            if (in_valid_r && i_ready) begin
                sent++;
                if (sent == total) accept_cyc = cyc + 1;
            end
            cyc++;
        end
        in_valid_r  = 1'b0;
        out_ready_r = 1'b1;
    endtask

    task automatic compare(input string name);
        check($sformatf("%s_count", name), got_d.size(), exp_d.size());
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            check($sformatf("%s_data%0d", name, i), got_d[i], exp_d[i]);
            check($sformatf("%s_end%0d", name, i), got_e[i], exp_e[i]);
        end
    endtask

    task automatic exp_from_table(input vec_t t);
        int ci = t.which ? 1 : 3;
        exp_d.delete();
        exp_e.delete();
        for (int c = 0; c < ci; c++) begin
            for (int i = 0; i < 4; i++) begin
                exp_d.push_back(t.v[i]);
                exp_e.push_back(c == ci - 1 && i == 3);
            end
        end
    endtask

    // Input activity during reset must be ignored.
    task automatic do_reset();
        @(negedge clk);
        rst         = 1'b1;
        in_valid_r  = 1'b1;
        ifm_r       = 16'h0063;
        out_ready_r = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst        = 1'b0;
        in_valid_r = 1'b0;
    endtask

    task automatic check_reset_state(input string name);
        for (int w = 0; w < 2; w++) begin
            sel = w;
            #1;
            check($sformatf("%s_in_ready%0d", name, w), i_ready, 1);
            check($sformatf("%s_out_valid%0d", name, w), o_valid, 0);
            check($sformatf("%s_data%0d", name, w), o_data, 0);
            check($sformatf("%s_end%0d", name, w), o_end, 0);
        end
        sel = 0;
    endtask

    initial begin
        int sent;
        rst         = 1'b1;
        mode_r      = 1'b0;
        in_valid_r  = 1'b0;
        out_ready_r = 1'b1;
        ifm_r       = '0;
        sel         = 0;

        tbl[0] = mk(1'b0, 1'b0, 2'd0, 5, 7, 13, 15);
        tbl[1] = mk(1'b0, 1'b1, 2'd0, 2, 4, 10, 12);
        tbl[2] = mk(1'b0, 1'b0, 2'd1, -1, -5, -9, -13);
        tbl[3] = mk(1'b0, 1'b1, 2'd1, -3, -7, -11, -15);
        tbl[4] = mk(1'b1, 1'b0, 2'd0, 4, 5, 7, 8);
        tbl[5] = mk(1'b1, 1'b1, 2'd0, 2, 3, 5, 6);

        do_reset();
        check_reset_state("reset");

        // Full-throughput frames against hand-computed results.
        for (int t = 0; t < 6; t++) begin
            make_frame(int'(tbl[t].kind), int'(tbl[t].which));
            exp_from_table(tbl[t]);
            run_frame(int'(tbl[t].which), tbl[t].m, 1'b0, 100000, 0, 1'b0);
            compare($sformatf("vec%0d", t));
            check($sformatf("vec%0d_throughput", t), accept_cyc, px_q.size());
        end

        // Downstream stall of 5 cycles while a beat is pending, mode toggled after frame start.
        make_frame(0, 0);
        exp_from_table(tbl[0]);
        run_frame(0, 1'b0, 1'b0, 8, 5, 1'b1);
        compare("stall");

        // Reset after 7 pixels of a frame, then a clean frame.
        make_frame(0, 0);
        sel  = 0;
        sent = 0;
        for (int cyc = 0; cyc < 30 && sent < 7; cyc++) begin
            @(negedge clk);
            in_valid_r  = 1'b1;
            ifm_r       = 16'(px_q[sent]);
            mode_r      = 1'b1;
            out_ready_r = 1'b1;
            #1;
            if (i_ready) sent++;
        end
        do_reset();
        check_reset_state("midrst");
        exp_from_table(tbl[0]);
        run_frame(0, 1'b0, 1'b0, 100000, 0, 1'b0);
        compare("midrst");

        // Random pixels and random handshakes against the reference model.
        for (int t = 0; t < 10; t++) begin
            int   which;
            logic m;
            which = t % 2;
            m     = 1'($urandom_range(0, 1));
            make_frame(2, which);
            model(which, m);
            run_frame(which, m, 1'b1, 100000, 0, 1'($urandom_range(0, 1)));
            compare($sformatf("rand%0d", t));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
